// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package elastic_pipe_pkg;

  // Wide default that callers truncate to their data width.
  localparam logic [63:0] DEF_RESET_VAL = 64'h0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid+data register of the elastic pipe with its link in the ready chain.
module elastic_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_next,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // An empty stage always accepts, which is what collapses bubbles.
  assign ready = !valid || ready_next;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (ready) begin
      valid <= valid_in;
      if (valid_in) data <= data_in;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage valid/ready register pipeline with flush and occupancy count.
module elastic_pipe_reg
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      flush,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH:0]                  rdy;
  logic [DEPTH-1:0]                vld, vin;
  logic [DEPTH-1:0][WIDTH-1:0]     dat, din;
  logic                            in_xfer, out_xfer;

  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign vin[i] = in_valid;
      assign din[i] = in_data;
    end else begin : g_body
      assign vin[i] = vld[i-1];
      assign din[i] = dat[i-1];
    end

    elastic_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .valid_in   (vin[i]),
      .data_in    (din[i]),
      .ready_next (rdy[i+1]),
      .ready      (rdy[i]),
      .valid      (vld[i]),
      .data       (dat[i])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Tracked incrementally rather than popcounted; in and out cancel when both fire.
  always_ff @(posedge clk) begin
    if (!rst || flush) count <= '0;
    else               count <= count + CW'(in_xfer) - CW'(out_xfer);
  end

endmodule
